apb_requester: RTL
==================

APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum ACCESS-phase wait cycles before abort (0 = never abort).
REQ-002 SHALL have port PCLK  input  1  system clock; one clock domain, all logic on rising edge.
REQ-003 SHALL have port PRESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid  input  1 / cmd_ready  output  1  command handshake.
REQ-005 SHALL have ports cmd_write  input  1 / cmd_addr  input  addr_t / cmd_wdata  input  data_t / cmd_strb  input  strb_t  command payload.
REQ-006 SHALL have ports rsp_valid  output  1 / rsp_ready  input  1  response handshake.
REQ-007 SHALL have ports rsp_rdata  output  data_t / rsp_slverr  output  1 / rsp_timeout  output  1  response payload.
REQ-008 SHALL have APB requester-side ports PSEL, PENABLE, PWRITE (output 1), PADDR (output addr_t), PWDATA (output data_t), PSTRB (output strb_t), PREADY, PSLVERR (input 1), PRDATA (input data_t).

Function
REQ-009 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-010 IDLE: cmd_ready=1; on cmd_valid, capture payload into APB output registers and go to SETUP.
REQ-011 SETUP (exactly one cycle): PSEL=1, PENABLE=0; then go to ACCESS unconditionally.
REQ-012 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA/PSTRB SHALL stay constant from SETUP until transfer end.
REQ-013 ACCESS with PREADY=1 at a rising edge: capture PRDATA (reads; 0 for writes) and PSLVERR into the response, clear PSEL/PENABLE, go to RESP.
REQ-014 ACCESS with PREADY=0: increment the wait counter; when count equals TIMEOUT_CYCLES (nonzero), clear PSEL/PENABLE, go to RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
REQ-015 The wait counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits, cleared on SETUP entry, and never wrap.
REQ-016 RESP: rsp_valid=1 with stable payload until rsp_ready=1; then go to IDLE.
REQ-017 cmd_ready SHALL be 0 in SETUP, ACCESS, and RESP; only one transfer is outstanding.
REQ-018 Reads SHALL drive PSTRB=0 and PWDATA=0 regardless of cmd_strb/cmd_wdata.
REQ-019 Latency: command accepted at edge N; SETUP in cycle N+1; ACCESS in N+2; with zero wait states, rsp_valid at N+3.
REQ-020 PSLVERR SHALL be sampled only when PSEL&PENABLE&PREADY and ignored otherwise.
REQ-021 In IDLE and RESP, PADDR/PWRITE/PWDATA/PSTRB SHALL hold their last values; PSEL=PENABLE=0.
REQ-022 A write with cmd_strb=0 SHALL still execute as a normal APB write.

Reset
REQ-023 PRESET=1 SHALL immediately force state IDLE and clear all outputs to 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, and the counter; cmd_ready becomes 1 once reset is released.
REQ-024 Reset mid-transfer or mid-response SHALL abort it silently; no response is produced after reset.

Structure
REQ-025 addr_t, data_t, strb_t, and the FSM state enum apb_req_state_e SHALL reside in apb_pkg.
REQ-026 Single flat module; no sub-module is warranted. The APB ports SHALL connect to the existing interface's requester-side modport.

Verification
REQ-027 Zero-wait write: addr 0x10, wdata 0xDEADBEEF, strb 0xF -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid at N+3, slverr=0, rdata=0.
REQ-028 Read with 3 wait states, PRDATA=0xCAFEF00D -> ACCESS 4 cycles, payload stable throughout, PSTRB=0, rsp_rdata=0xCAFEF00D.
REQ-029 Completer error: PSLVERR=1 with PREADY on a read at addr 0x3FC -> rsp_slverr=1, rsp_timeout=0.
REQ-030 Timeout with TIMEOUT_CYCLES=4, PREADY held 0 -> PSEL drops after 4 ACCESS cycles; rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
REQ-031 Backpressure: rsp_ready low for 5 cycles -> rsp_valid and payload held, cmd_ready=0, a new cmd_valid is not accepted until the cycle after the response handshake.
REQ-032 PRESET pulsed during ACCESS -> all outputs 0 asynchronously, no rsp_valid; a subsequent command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB types and the requester FSM state encoding.
// Bus widths are fixed here so requester and completer agree on them.
package apb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [STRB_W-1:0] strb_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_req_state_e;

    typedef struct packed {
        data_t rdata;
        logic  slverr;
        logic  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: turns one command into a SETUP/ACCESS
// transfer with an optional wait-state timeout, then holds the response.
module apb_requester
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic  PCLK,
    input  logic  PRESET,

    input  logic  cmd_valid,
    output logic  cmd_ready,
    input  logic  cmd_write,
    input  addr_t cmd_addr,
    input  data_t cmd_wdata,
    input  strb_t cmd_strb,

    output logic  rsp_valid,
    input  logic  rsp_ready,
    output data_t rsp_rdata,
    output logic  rsp_slverr,
    output logic  rsp_timeout,

    output logic  PSEL,
    output logic  PENABLE,
    output logic  PWRITE,
    output addr_t PADDR,
    output data_t PWDATA,
    output strb_t PSTRB,
    input  logic  PREADY,
    input  logic  PSLVERR,
    input  data_t PRDATA
);

    localparam int   CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit   TO_EN  = (TIMEOUT_CYCLES > 0);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;
    localparam cnt_t CNT_LIM = cnt_t'(TIMEOUT_CYCLES);

    apb_req_state_e state_q;
    cnt_t           cnt_q;
    cnt_t           cnt_d;
    logic           psel_q, penable_q, pwrite_q;
    addr_t          paddr_q;
    data_t          pwdata_q;
    strb_t          pstrb_q;
    logic           rsp_valid_q;
    apb_rsp_t       rsp_q;

    // Saturating increment so the counter can never wrap, even with timeout disabled.
    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr_q  <= cmd_addr;
                        pwrite_q <= cmd_write;
                        pwdata_q <= cmd_write ? cmd_wdata : '0;
                        pstrb_q  <= cmd_write ? cmd_strb  : '0;
                        psel_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_q.rdata   <= pwrite_q ? '0 : PRDATA;
                        rsp_q.slverr  <= PSLVERR;
                        rsp_q.timeout <= 1'b0;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else if (TO_EN && cnt_d == CNT_LIM) begin
                        rsp_q.rdata   <= '0;
                        rsp_q.slverr  <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                        cnt_q         <= cnt_d;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == IDLE) && !PRESET;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_slverr  = rsp_q.slverr;
    assign rsp_timeout = rsp_q.timeout;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;

endmodule
